// File: rtl/frotaegis_pkg.sv
// Shared definitions for the frame report transmitter.
//   PKT_HEADER : packet start byte
//   PKT_LEN    : bytes per packet (header, seq, 6 result bytes, 64 samples, checksum)
//   OFF_*      : byte offsets of the result field, sample field and checksum
//   txState_t  : transmitter FSM states
package frotaegis_pkg;

   localparam logic [7:0] PKT_HEADER = 8'hA5;
   localparam int PKT_LEN  = 73;
   localparam int IDX_W    = $clog2(PKT_LEN);
   localparam int OFF_RES  = 2;
   localparam int OFF_DATA = 8;
   localparam int OFF_CSUM = 72;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      SEND = 2'd2
   } txState_t;

endpackage

// File: rtl/frame_buf.sv
// Frame sample store: LENGTH x DATA_SIZE register array.
//   clk    : clock
//   we     : write enable, mem[addr] <= din at the clock edge
//   addr   : write address
//   din    : write data
//   rdAddr : read address (combinational read)
//   rdData : read data
// Contents are intentionally not reset.
module frame_buf #(
   parameter int DATA_SIZE   = 4,
   parameter int LENGTH      = 64,
   parameter int LENGTH_SIZE = 6
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [LENGTH_SIZE-1:0] addr,
   input  logic [DATA_SIZE-1:0]   din,
   input  logic [LENGTH_SIZE-1:0] rdAddr,
   output logic [DATA_SIZE-1:0]   rdData
);

   logic [DATA_SIZE-1:0] mem [LENGTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/frame_report_tx.sv
// Captures one histogram frame readout plus the three top-count results and
// sends them to the host link as a checksummed 73-byte packet on a
// valid/ready byte stream.
//   clk, rst                       : clock, synchronous active-high reset
//   FramEn/FramAdd/FramData        : frame readout write port
//   SortValid, MaxCountData1..3,
//   MaxCount1..3                   : top-count results, valid with SortValid
//   TxValid/TxData/TxLast/TxReady  : registered byte stream toward the host
//   Busy                           : packet being sent
//   Overrun                        : one-cycle pulse per frame dropped while busy
module frame_report_tx
   import frotaegis_pkg::*;
#(
   parameter int         DATA_SIZE   = 4,
   parameter int         LENGTH      = 64,
   parameter int         LENGTH_SIZE = 6,
   parameter logic [7:0] HEADER      = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   FramEn,
   input  logic [LENGTH_SIZE-1:0] FramAdd,
   input  logic [DATA_SIZE-1:0]   FramData,
   input  logic                   SortValid,
   input  logic [DATA_SIZE-1:0]   MaxCountData1,
   input  logic [DATA_SIZE-1:0]   MaxCountData2,
   input  logic [DATA_SIZE-1:0]   MaxCountData3,
   input  logic [LENGTH_SIZE-1:0] MaxCount1,
   input  logic [LENGTH_SIZE-1:0] MaxCount2,
   input  logic [LENGTH_SIZE-1:0] MaxCount3,
   output logic                   TxValid,
   output logic [7:0]             TxData,
   output logic                   TxLast,
   input  logic                   TxReady,
   output logic                   Busy,
   output logic                   Overrun
);

   txState_t state;
   logic frameDone, resDone, lostFrame;
   logic [DATA_SIZE-1:0]   resData1, resData2, resData3;
   logic [LENGTH_SIZE-1:0] resCnt1, resCnt2, resCnt3;
   logic [7:0]       seq, csum, sumNext, nextByte;
   logic [IDX_W-1:0] byteIdx, nextIdx;
   logic [LENGTH_SIZE-1:0] rdAddr;
   logic [DATA_SIZE-1:0]   rdData;
   logic handshake, firstAddr, lastAddr, goSend, sendLike, captureEn;

   assign handshake = TxValid && TxReady;
   assign firstAddr = (FramAdd == '0);
   assign lastAddr  = (FramAdd == LENGTH_SIZE'(LENGTH - 1));
   assign goSend    = (state == CAPT) && frameDone && resDone;
   // The cycle that commits to SEND already behaves as SEND: the buffer and
   // results are frozen, so a frame starting in that cycle is dropped too.
   assign sendLike  = (state == SEND) || goSend;
   // After a drop, the tail of the lost frame must not open a new capture.
   assign captureEn = FramEn && !sendLike && !(lostFrame && !firstAddr);
   assign Busy      = (state == SEND);

   frame_buf #(
      .DATA_SIZE  (DATA_SIZE),
      .LENGTH     (LENGTH),
      .LENGTH_SIZE(LENGTH_SIZE)
   ) uBuf (
      .clk   (clk),
      .we    (captureEn),
      .addr  (FramAdd),
      .din   (FramData),
      .rdAddr(rdAddr),
      .rdData(rdData)
   );

   // Byte that follows the one currently on TxData. The checksum byte uses
   // the running sum including the byte being accepted now.
   always_comb begin
      sumNext  = csum + TxData;
      nextIdx  = byteIdx + IDX_W'(1);
      rdAddr   = LENGTH_SIZE'(nextIdx - IDX_W'(OFF_DATA));
      nextByte = 8'(rdData);
      case (nextIdx)
         IDX_W'(1):           nextByte = seq;
         IDX_W'(OFF_RES):     nextByte = 8'(resData1);
         IDX_W'(OFF_RES + 1): nextByte = 8'(resCnt1);
         IDX_W'(OFF_RES + 2): nextByte = 8'(resData2);
         IDX_W'(OFF_RES + 3): nextByte = 8'(resCnt2);
         IDX_W'(OFF_RES + 4): nextByte = 8'(resData3);
         IDX_W'(OFF_RES + 5): nextByte = 8'(resCnt3);
         IDX_W'(OFF_CSUM):    nextByte = sumNext;
         default:             nextByte = 8'(rdData);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         frameDone <= 1'b0;
         resDone   <= 1'b0;
         lostFrame <= 1'b0;
         seq       <= '0;
         csum      <= '0;
         byteIdx   <= '0;
         TxValid   <= 1'b0;
         TxData    <= '0;
         TxLast    <= 1'b0;
         Overrun   <= 1'b0;
      end else begin
         Overrun <= FramEn && firstAddr && sendLike;
         if (FramEn && firstAddr && sendLike)          lostFrame <= 1'b1;
         else if (FramEn && (firstAddr || lastAddr))   lostFrame <= 1'b0;

         if (SortValid && !sendLike) begin
            resData1 <= MaxCountData1;
            resData2 <= MaxCountData2;
            resData3 <= MaxCountData3;
            resCnt1  <= MaxCount1;
            resCnt2  <= MaxCount2;
            resCnt3  <= MaxCount3;
            resDone  <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (captureEn) begin
                  state     <= CAPT;
                  frameDone <= lastAddr;
               end
            end
            CAPT: begin
               if (goSend) begin
                  state   <= SEND;
                  byteIdx <= '0;
                  csum    <= '0;
                  TxValid <= 1'b1;
                  TxData  <= HEADER;
                  TxLast  <= 1'b0;
               end else if (FramEn) begin
                  // address 0 restarts the burst; results stay latched
                  if (lastAddr)       frameDone <= 1'b1;
                  else if (firstAddr) frameDone <= 1'b0;
               end
            end
            SEND: begin
               if (handshake) begin
                  if (byteIdx == IDX_W'(OFF_CSUM)) begin
                     state     <= IDLE;
                     TxValid   <= 1'b0;
                     TxData    <= '0;
                     TxLast    <= 1'b0;
                     seq       <= seq + 8'd1;
                     frameDone <= 1'b0;
                     resDone   <= 1'b0;
                  end else begin
                     byteIdx <= nextIdx;
                     TxData  <= nextByte;
                     TxLast  <= (nextIdx == IDX_W'(OFF_CSUM));
                     csum    <= sumNext;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_report_tx.sv
module tb_frame_report_tx;

   logic       clk = 1'b0;
   logic       rst, FramEn, SortValid, TxReady, TxValid, TxLast, Busy, Overrun;
   logic [5:0] FramAdd, MaxCount1, MaxCount2, MaxCount3;
   logic [3:0] FramData, MaxCountData1, MaxCountData2, MaxCountData3;
   logic [7:0] TxData;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   frame_report_tx dut (
      .clk(clk), .rst(rst), .FramEn(FramEn), .FramAdd(FramAdd), .FramData(FramData),
      .SortValid(SortValid),
      .MaxCountData1(MaxCountData1), .MaxCountData2(MaxCountData2), .MaxCountData3(MaxCountData3),
      .MaxCount1(MaxCount1), .MaxCount2(MaxCount2), .MaxCount3(MaxCount3),
      .TxValid(TxValid), .TxData(TxData), .TxLast(TxLast), .TxReady(TxReady),
      .Busy(Busy), .Overrun(Overrun)
   );

   int nVec = 0, nErr = 0;
   int readyMode = 0;

   // stream monitor (sole writer of everything below)
   logic [7:0] rxQ[$];
   int hsCycQ[$], lastQ[$], riseQ[$];
   int ovCnt = 0, stallErr = 0, stallCnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin : mon
      logic pv, pstall, pl;
      logic [7:0] pd;
      pv = 1'b0; pstall = 1'b0; pl = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (pstall && (TxValid !== 1'b1 || TxData !== pd || TxLast !== pl)) stallErr++;
         if (TxValid === 1'b1 && pv !== 1'b1) riseQ.push_back(cyc);
         if (TxValid === 1'b1 && TxReady === 1'b1) begin
            rxQ.push_back(TxData);
            hsCycQ.push_back(cyc);
            if (TxLast === 1'b1) lastQ.push_back(rxQ.size() - 1);
         end
         if (Overrun === 1'b1) ovCnt++;
         pstall = (TxValid === 1'b1) && (TxReady !== 1'b1);
         if (pstall) stallCnt++;
         pv = TxValid; pd = TxData; pl = TxLast;
      end
   end

   // sink: always ready, or the repeating 1,0,0 pattern
   initial begin
      TxReady = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         TxReady = (readyMode == 0) || (cyc % 3 == 0);
      end
   end

   task automatic doRst;
      rst = 1'b1; FramEn = 1'b0; SortValid = 1'b0;
      step; step;
      rst = 1'b0;
      step;
   endtask

   // one burst of consecutive addresses; lastCyc is the input cycle of the final sample
   task automatic burst(input int first, input int last, input bit fixedF, input int sortAt,
                        output int lastCyc);
      lastCyc = 0;
      for (int a = first; a <= last; a++) begin
         FramEn    = 1'b1;
         FramAdd   = 6'(a);
         FramData  = fixedF ? 4'hF : 4'(a);
         SortValid = ((a - first) == sortAt);
         lastCyc   = cyc;
         step;
      end
      FramEn = 1'b0; SortValid = 1'b0;
   endtask

   task automatic waitLast(input string tag, input int target);
      int n;
      n = 0;
      while (lastQ.size() < target && n < 600) begin
         step;
         n++;
      end
      chk({tag, "_done"}, 32'(lastQ.size() >= target), 1);
   endtask

   // expected packet for the standard results and FramData = addr[3:0]
   task automatic checkPkt(input string tag, input int base, input int lb, input logic [7:0] s);
      logic [7:0] e [73];
      logic [7:0] sum;
      e[0] = 8'hA5; e[1] = s;
      e[2] = 8'd3; e[3] = 8'd20; e[4] = 8'd7; e[5] = 8'd15; e[6] = 8'd1; e[7] = 8'd9;
      for (int i = 0; i < 64; i++) e[8+i] = 8'(i % 16);
      sum = '0;
      for (int i = 0; i < 72; i++) sum = sum + e[i];
      e[72] = sum;
      chk({tag, "_len"}, 32'(rxQ.size() - base), 73);
      for (int i = 0; i < 73; i++)
         chk($sformatf("%s_b%0d", tag, i),
             (base + i < rxQ.size()) ? 32'(rxQ[base+i]) : 32'hDEAD, 32'(e[i]));
      chk({tag, "_lastpos"}, (lb < lastQ.size()) ? 32'(lastQ[lb]) : 32'hDEAD, 32'(base + 72));
   endtask

   int base, lb, rb, ov0, st0, lc, sc, n;

   initial begin
      rst = 1'b1; FramEn = 1'b0; SortValid = 1'b0; FramAdd = '0; FramData = '0;
      MaxCountData1 = 4'd3; MaxCount1 = 6'd20;
      MaxCountData2 = 4'd7; MaxCount2 = 6'd15;
      MaxCountData3 = 4'd1; MaxCount3 = 6'd9;

      // reset state
      doRst;
      chk("rst_valid", 32'(TxValid), 0);
      chk("rst_data",  32'(TxData), 0);
      chk("rst_last",  32'(TxLast), 0);
      chk("rst_busy",  32'(Busy), 0);
      chk("rst_ovr",   32'(Overrun), 0);

      // 1: basic packet, sink always ready
      base = rxQ.size(); lb = lastQ.size(); rb = riseQ.size();
      burst(0, 63, 0, 20, lc);
      chk("s1_busy_capt", 32'(Busy), 0);
      waitLast("s1", lb + 1);
      chk("s1_valid_after", 32'(TxValid), 0);
      chk("s1_busy_after",  32'(Busy), 0);
      checkPkt("s1", base, lb, 8'h00);
      chk("s1_csum_const", (base + 72 < rxQ.size()) ? 32'(rxQ[base+72]) : 32'hDEAD, 32'hBC);
      chk("s1_rise", (rb < riseQ.size()) ? 32'(riseQ[rb]) : 32'hDEAD, 32'(lc + 2));
      chk("s1_nobubble", (base + 72 < hsCycQ.size()) ? 32'(hsCycQ[base+72] - hsCycQ[base]) : 32'hDEAD, 72);

      // 2: back-pressure
      doRst;
      readyMode = 1;
      st0 = stallCnt;
      base = rxQ.size(); lb = lastQ.size();
      burst(0, 63, 0, 20, lc);
      waitLast("s2", lb + 1);
      checkPkt("s2", base, lb, 8'h00);
      chk("s2_stalled", 32'(stallCnt > st0), 1);
      readyMode = 0;
      step;

      // 3: results arrive 10 cycles after the burst
      doRst;
      base = rxQ.size(); lb = lastQ.size(); rb = riseQ.size();
      burst(0, 63, 0, -1, lc);
      repeat (9) step;
      SortValid = 1'b1; sc = cyc;
      step;
      SortValid = 1'b0;
      chk("s3_sortcyc", 32'(sc - lc), 10);
      chk("s3_early", 32'(riseQ.size() - rb), 0);
      waitLast("s3", lb + 1);
      checkPkt("s3", base, lb, 8'h00);
      chk("s3_rise", (rb < riseQ.size()) ? 32'(riseQ[rb]) : 32'hDEAD, 32'(sc + 2));

      // 4: second frame back-to-back is dropped; third frame after idle
      doRst;
      base = rxQ.size(); lb = lastQ.size(); ov0 = ovCnt;
      burst(0, 63, 0, 20, lc);
      burst(0, 63, 1, 20, lc);
      waitLast("s4a", lb + 1);
      repeat (100) step;
      chk("s4_nosecond", 32'(rxQ.size() - base), 73);
      chk("s4_overrun", 32'(ovCnt - ov0), 1);
      checkPkt("s4a", base, lb, 8'h00);
      base = rxQ.size(); lb = lastQ.size();
      burst(0, 63, 0, 20, lc);
      waitLast("s4b", lb + 1);
      checkPkt("s4b", base, lb, 8'h01);

      // 5: reset mid-packet
      doRst;
      base = rxQ.size();
      burst(0, 63, 0, 20, lc);
      n = 0;
      while (rxQ.size() < base + 30 && n < 300) begin
         step;
         n++;
      end
      chk("s5_reach30", 32'(rxQ.size() >= base + 30), 1);
      rst = 1'b1;
      step;
      chk("s5_abort_valid", 32'(TxValid), 0);
      chk("s5_abort_busy",  32'(Busy), 0);
      rst = 1'b0;
      step;
      base = rxQ.size(); lb = lastQ.size();
      burst(0, 63, 0, 20, lc);
      waitLast("s5", lb + 1);
      checkPkt("s5", base, lb, 8'h00);

      // 6: restart mid-burst, only the second burst is sent
      doRst;
      base = rxQ.size(); lb = lastQ.size(); rb = riseQ.size();
      burst(0, 40, 1, 20, lc);
      burst(0, 63, 0, -1, lc);
      waitLast("s6", lb + 1);
      checkPkt("s6", base, lb, 8'h00);
      chk("s6_rise", (rb < riseQ.size()) ? 32'(riseQ[rb]) : 32'hDEAD, 32'(lc + 2));

      step;
      chk("stall_hold", 32'(stallErr), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
